// File: rtl/mul_seq.sv
// mul_seq: operand FIFO and issue sequencer for the iterative multiplier, with a result register and a watchdog
module mul_seq #(
  parameter int DEPTH = 4,
  parameter int TMO = 64
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_start,
  input  logic [16:0] mul_o,
  input  logic        mul_fin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_a,
  output logic [7:0]  out_b,
  output logic [16:0] out_p,
  output logic        err,
  output logic        busy,
  output logic [15:0] done_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TMO);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state, nxt;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [WW-1:0] wdog;
  logic push, pop, fin_ok, tmo;
  always_ff @(posedge ck or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = (state == IDLE && pop) ? WAIT :
          (state == WAIT && fin_ok) ? HOLD :
          (state == WAIT && tmo) ? IDLE :
          (state == HOLD && out_ready) ? IDLE : state;
  // wdog==0 marks the first WAIT cycle, where a stale fin must be ignored
  always_comb begin
    in_ready = cnt != (AW+1)'(DEPTH);
    busy = state != IDLE || cnt != '0;
    push = in_valid && in_ready;
    pop = state == IDLE && cnt != '0;
    fin_ok = state == WAIT && wdog != '0 && mul_fin;
    tmo = state == WAIT && !fin_ok && wdog == WW'(TMO - 1);
  end
  always_ff @(posedge ck)
    if (push) mem[wp] <= {in_a, in_b};
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      mul_start <= 1'b0;
      out_a <= '0;
      out_b <= '0;
      out_p <= '0;
      out_valid <= 1'b0;
      err <= 1'b0;
      done_cnt <= '0;
      wdog <= '0;
    end else begin
      mul_start <= pop;
      err <= tmo;
      if (pop) begin
        {mul_a, mul_b} <= mem[rp];
        {out_a, out_b} <= mem[rp];
        wdog <= '0;
      end else if (state == WAIT) wdog <= wdog + 1'b1;
      if (fin_ok) begin
        out_p <= mul_o;
        out_valid <= 1'b1;
        done_cnt <= done_cnt + 16'd1;
      end else if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed checks of mul_seq against an 8-cycle behavioural multiplier
module tb_mul_seq;
  logic ck = 0, rst = 1, in_valid = 0, out_ready = 1, mul_fin, fin_en = 1;
  logic [7:0] in_a = 0, in_b = 0, mul_a, mul_b, out_a, out_b;
  logic [16:0] mul_o, out_p, prod;
  logic in_ready, mul_start, out_valid, err, busy;
  logic [15:0] done_cnt;
  logic [3:0] mc;
  int n_tests = 0, n_fail = 0;
  logic [16:0] fp [5] = '{17'd2, 17'd12, 17'd30, 17'd56, 17'd90};
  always #5 ck = ~ck;
  mul_seq #(.DEPTH(4), .TMO(16)) dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_o(mul_o), .mul_fin(mul_fin),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_p(out_p),
    .err(err), .busy(busy), .done_cnt(done_cnt)
  );
  always @(posedge ck or posedge rst)
    if (rst) begin
      mc <= 0;
      mul_fin <= 0;
      mul_o <= 0;
      prod <= 0;
    end else begin
      mul_fin <= 0;
      if (mul_start) begin
        mc <= 8;
        prod <= {9'd0, mul_a} * {9'd0, mul_b};
      end else if (mc != 0) begin
        mc <= mc - 1;
        if (mc == 1) begin
          mul_fin <= fin_en;
          mul_o <= prod;
        end
      end
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge ck);
    #1;
  endtask
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1;
    in_a = a;
    in_b = b;
    step();
    in_valid = 0;
  endtask
  task automatic wait_res(input logic [7:0] ea, input logic [7:0] eb, input logic [16:0] ep);
    logic seen = 0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      if (mul_start) seen = 1;
      if (seen) chk("mul_ab_hold", {mul_a, mul_b}, {ea, eb});
      step();
    end
    chk("out_valid", out_valid, 1);
    chk("out_ab", {out_a, out_b}, {ea, eb});
    chk("out_p", out_p, ep);
  endtask
  initial begin
    int k, bad;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ctl", {out_valid, mul_start, err, busy}, 0);
    chk("rst_mul_ab", {mul_a, mul_b}, 0);
    chk("rst_out", {out_a, out_b, out_p}, 0);
    chk("rst_done", done_cnt, 0);
    rst = 0;
    step();
    push(8'h0F, 8'h0F);
    chk("start_early", mul_start, 0);
    chk("busy_queued", busy, 1);
    step();
    chk("start_pulse", mul_start, 1);
    chk("issue_ab", {mul_a, mul_b}, 16'h0F0F);
    step();
    chk("start_one_cycle", mul_start, 0);
    wait_res(8'h0F, 8'h0F, 17'h000E1);
    chk("done_1", done_cnt, 1);
    step();
    push(8'hFF, 8'hFF);
    push(8'h00, 8'hFF);
    wait_res(8'hFF, 8'hFF, 17'h0FE01);
    step();
    wait_res(8'h00, 8'hFF, 17'h00000);
    chk("done_3", done_cnt, 3);
    step();
    out_ready = 0;
    for (int i = 0; i < 5; i++) push(8'(2 * i + 1), 8'(2 * i + 2));
    in_valid = 1;
    in_a = 8'd11;
    in_b = 8'd12;
    #1;
    chk("full_in_ready", in_ready, 0);
    in_valid = 0;
    wait_res(8'd1, 8'd2, fp[0]);
    step();
    step();
    chk("full_hold", {out_valid, in_ready, busy}, 3'b101);
    out_ready = 1;
    step();
    chk("full_no_issue", {in_ready, mul_start}, 0);
    step();
    chk("full_pop", {in_ready, mul_start}, 2'b11);
    for (int i = 1; i < 5; i++) begin
      wait_res(8'(2 * i + 1), 8'(2 * i + 2), fp[i]);
      step();
    end
    chk("done_8", done_cnt, 8);
    out_ready = 0;
    push(8'h12, 8'h34);
    wait_res(8'h12, 8'h34, 17'h003A8);
    push(8'd2, 8'd3);
    for (int i = 0; i < 20; i++) begin
      chk("bp_stable", {out_valid, mul_start, out_p}, {1'b1, 1'b0, 17'h003A8});
      step();
    end
    out_ready = 1;
    step();
    chk("bp_accept", {out_valid, mul_start}, 0);
    step();
    chk("bp_issue", mul_start, 1);
    wait_res(8'd2, 8'd3, 17'd6);
    step();
    chk("done_10", done_cnt, 10);
    fin_en = 0;
    push(8'd5, 8'd5);
    push(8'd6, 8'd6);
    chk("wd_start", mul_start, 1);
    k = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      k++;
      if (out_valid) bad++;
      if (err) break;
    end
    chk("wd_delay", k, 16);
    chk("wd_no_valid", bad, 0);
    fin_en = 1;
    step();
    chk("wd_err_once", err, 0);
    chk("wd_next_issue", {mul_start, mul_a}, {1'b1, 8'd6});
    wait_res(8'd6, 8'd6, 17'd36);
    step();
    chk("done_11", done_cnt, 11);
    push(8'd1, 8'd1);
    push(8'd2, 8'd2);
    push(8'd3, 8'd3);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("arst_ctl", {mul_start, out_valid, err, busy}, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_regs", {mul_a, mul_b, out_a, out_b}, 0);
    chk("arst_done", {done_cnt, out_p}, 0);
    @(negedge ck);
    rst = 0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mul_start || out_valid || busy) bad++;
    end
    chk("arst_quiet", bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
